// File: rtl/branch_predict_unit.sv
// Conditional-branch resolver with a one-cycle registered result and a bimodal
// 2-bit-counter BHT for fetch prediction. Optional counters: BRANCH_STATS_EN.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic [XLEN-1:0] res_imm,
  input  logic [XLEN-1:0] rs1_d,
  input  logic [XLEN-1:0] rs2_d,
  input  logic [2:0]      funct3,
  input  logic            res_pred_taken,
  input  logic            flush,
  output logic            out_valid,
  output logic            branch,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mispredict,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic            illegal
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [IDX-1:0]  pred_idx_s;
  logic [IDX-1:0]  res_idx_s;
  logic            cond_s;
  logic            legal_s;
  logic            accept_s;
  logic            upd_en_s;
  logic [1:0]      cnt_cur_s;
  logic [1:0]      cnt_d;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] seq_pc_s;
  logic            unused_pred_s;

  logic            out_valid_q;
  logic            branch_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] redirect_q;
  logic            mispredict_q;
  logic            illegal_q;

  assign pred_idx_s    = pred_pc[IDX+1:2];
  assign res_idx_s     = res_pc[IDX+1:2];
  assign unused_pred_s = ^{pred_pc[XLEN-1:IDX+2], pred_pc[1:0]};
  assign pred_taken    = bht_q[pred_idx_s][1];

  assign target_s = res_pc + res_imm;
  assign seq_pc_s = res_pc + {{(XLEN-3){1'b0}}, 3'b100};

  // Branch condition decode; 010/011 are not branch encodings.
  always_comb begin
    cond_s  = 1'b0;
    legal_s = 1'b1;
    case (funct3)
      3'b000:  cond_s = (rs1_d == rs2_d);
      3'b001:  cond_s = (rs1_d != rs2_d);
      3'b100:  cond_s = ($signed(rs1_d) <  $signed(rs2_d));
      3'b101:  cond_s = ($signed(rs1_d) >= $signed(rs2_d));
      3'b110:  cond_s = (rs1_d <  rs2_d);
      3'b111:  cond_s = (rs1_d >= rs2_d);
      default: begin
        cond_s  = 1'b0;
        legal_s = 1'b0;
      end
    endcase
  end

  assign accept_s  = res_valid && !flush;
  assign upd_en_s  = accept_s && legal_s;
  assign cnt_cur_s = bht_q[res_idx_s];

  // Saturating counter step for the resolving branch's entry.
  always_comb begin
    cnt_d = cnt_cur_s;
    if (cond_s) begin
      if (cnt_cur_s != 2'b11) begin
        cnt_d = cnt_cur_s + 2'b01;
      end else begin
        cnt_d = cnt_cur_s;
      end
    end else begin
      if (cnt_cur_s != 2'b00) begin
        cnt_d = cnt_cur_s - 2'b01;
      end else begin
        cnt_d = cnt_cur_s;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;
`endif

  // Result registers and BHT; non-accepted cycles hold the last result fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      branch_q     <= 1'b0;
      target_q     <= {XLEN{1'b0}};
      redirect_q   <= {XLEN{1'b0}};
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
`ifdef BRANCH_STATS_EN
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
`endif
    end else begin
      out_valid_q <= accept_s;
      if (accept_s) begin
        branch_q     <= legal_s && cond_s;
        target_q     <= target_s;
        redirect_q   <= (legal_s && cond_s) ? target_s : seq_pc_s;
        mispredict_q <= legal_s && (cond_s != res_pred_taken);
        illegal_q    <= !legal_s;
      end
      if (upd_en_s) begin
        bht_q[res_idx_s] <= cnt_d;
`ifdef BRANCH_STATS_EN
        stat_br_q <= stat_br_q + 32'd1;
        if (cond_s != res_pred_taken) begin
          stat_mp_q <= stat_mp_q + 32'd1;
        end
`endif
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign branch      = branch_q;
  assign target      = target_q;
  assign redirect_pc = redirect_q;
  assign mispredict  = mispredict_q;
  assign illegal     = illegal_q;
`ifdef BRANCH_STATS_EN
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized bench for branch_predict_unit with an in-bench behavioural model.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc, res_imm, rs1_d, rs2_d;
  logic [2:0]  funct3;
  logic        res_pred_taken, flush;
  logic        out_valid, branch, mispredict, illegal;
  logic [31:0] target, redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_imm(res_imm),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .funct3(funct3),
    .res_pred_taken(res_pred_taken), .flush(flush),
    .out_valid(out_valid), .branch(branch), .target(target),
    .redirect_pc(redirect_pc), .mispredict(mispredict),
`ifdef BRANCH_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int          bht_m [64];
  bit          ready = 1'b0;
  bit          fk    = 1'b0;
  bit          ev, eb, em, ei;
  logic [31:0] et, er;
  int unsigned sb, sm;

  function automatic bit cond_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Compare outputs of the previous sampled cycle, then advance the model with
  // the inputs the DUT will sample at the coming rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (ready) begin
        chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
        if (fk) begin
          chk("branch", {63'd0, branch}, {63'd0, eb});
          chk("target", {32'd0, target}, {32'd0, et});
          chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, er});
          chk("mispredict", {63'd0, mispredict}, {63'd0, em});
          chk("illegal", {63'd0, illegal}, {63'd0, ei});
        end
        chk("pred_taken", {63'd0, pred_taken}, {63'd0, bht_m[(pred_pc >> 2) % 64] >= 2});
`ifdef BRANCH_STATS_EN
        chk("stat_branches", {32'd0, stat_branches}, {32'd0, sb});
        chk("stat_mispredicts", {32'd0, stat_mispredicts}, {32'd0, sm});
`endif
      end
      if (rst) begin
        ev = 0; eb = 0; em = 0; ei = 0; et = 32'd0; er = 32'd0; fk = 1;
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        sb = 0; sm = 0; ready = 1;
      end else if (res_valid && !flush) begin
        bit lg, tk;
        int ix;
        lg = !(funct3 == 3'd2 || funct3 == 3'd3);
        tk = lg && cond_of(funct3, rs1_d, rs2_d);
        ev = 1; fk = 1;
        eb = tk;
        et = res_pc + res_imm;
        er = tk ? et : res_pc + 32'd4;
        em = lg && (tk != res_pred_taken);
        ei = !lg;
        if (lg) begin
          ix = (res_pc >> 2) % 64;
          if (tk) bht_m[ix] = (bht_m[ix] == 3) ? 3 : bht_m[ix] + 1;
          else    bht_m[ix] = (bht_m[ix] == 0) ? 0 : bht_m[ix] - 1;
          sb++;
          if (em) sm++;
        end
      end else if (res_valid) begin
        ev = 0; fk = 0;
      end else begin
        ev = 0;
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic pt, input logic fl);
    @(posedge clk);
    #1;
    res_valid = v; res_pc = pc; res_imm = imm; rs1_d = a; rs2_d = b;
    funct3 = f3; res_pred_taken = pt; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    rst = 1'b1; pred_pc = 32'd0;
    res_valid = 1'b0; res_pc = 32'd0; res_imm = 32'd0; rs1_d = 32'd0; rs2_d = 32'd0;
    funct3 = 3'd0; res_pred_taken = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; pred_pc = 32'h100;
    #1;
    chk("rst_pred", {63'd0, pred_taken}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_target", {32'd0, target}, 64'd0);
    chk("rst_redirect", {32'd0, redirect_pc}, 64'd0);
    chk("rst_mispredict", {63'd0, mispredict}, 64'd0);

    drive(1'b1, 32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0, 1'b0);
    idle();
    chk("beq_valid", {63'd0, out_valid}, 64'd1);
    chk("beq_branch", {63'd0, branch}, 64'd1);
    chk("beq_target", {32'd0, target}, 64'h120);
    chk("beq_redirect", {32'd0, redirect_pc}, 64'h120);
    chk("beq_mispredict", {63'd0, mispredict}, 64'd1);
    chk("beq_pred_after", {63'd0, pred_taken}, 64'd1);

    drive(1'b1, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0, 1'b0);
    drive(1'b1, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b1, 1'b0);
    #1;
    chk("blt_branch", {63'd0, branch}, 64'd1);
    idle();
    chk("bltu_branch", {63'd0, branch}, 64'd0);
    chk("bltu_redirect", {32'd0, redirect_pc}, 64'h204);
    chk("bltu_mispredict", {63'd0, mispredict}, 64'd1);

    pred_pc = 32'h300;
    drive(1'b1, 32'h300, 32'h10, 32'd7, 32'd7, 3'b000, 1'b0, 1'b0);
    idle();
    chk("ctr_first_taken", {63'd0, pred_taken}, 64'd1);
    drive(1'b1, 32'h300, 32'h10, 32'd7, 32'd7, 3'b000, 1'b1, 1'b0);
    drive(1'b1, 32'h300, 32'h10, 32'd7, 32'd7, 3'b000, 1'b1, 1'b0);
    drive(1'b1, 32'h300, 32'h10, 32'd7, 32'd7, 3'b001, 1'b1, 1'b0);
    idle();
    chk("ctr_after_nt", {63'd0, pred_taken}, 64'd1);

    drive(1'b1, 32'h300, 32'h8, 32'd1, 32'd1, 3'b010, 1'b1, 1'b0);
    idle();
    chk("ill_illegal", {63'd0, illegal}, 64'd1);
    chk("ill_branch", {63'd0, branch}, 64'd0);
    chk("ill_mispredict", {63'd0, mispredict}, 64'd0);
    chk("ill_redirect", {32'd0, redirect_pc}, 64'h304);
    drive(1'b1, 32'h300, 32'h8, 32'd1, 32'd1, 3'b001, 1'b1, 1'b0);
    idle();
    chk("ill_bht_kept", {63'd0, pred_taken}, 64'd0);

    pred_pc = 32'h400;
    drive(1'b1, 32'h400, 32'h8, 32'd1, 32'd2, 3'b001, 1'b0, 1'b1);
    idle();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_bht", {63'd0, pred_taken}, 64'd0);

    drive(1'b1, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0);
    idle();
    chk("wrap_target", {32'd0, target}, 64'h10);
    chk("wrap_redirect", {32'd0, redirect_pc}, 64'h10);

    pred_pc = 32'h300;
    drive(1'b1, 32'h300, 32'h0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0);
    drive(1'b1, 32'h300, 32'h0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("pend_valid", {63'd0, out_valid}, 64'd1);
    chk("pend_pred", {63'd0, pred_taken}, 64'd1);
    @(posedge clk);
    #2;
    chk("rst_drop_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_no_update", {63'd0, pred_taken}, 64'd0);
    rst = 1'b0;
    idle();

    for (int n = 0; n < 2500; n++) begin
      logic [31:0] b, a, pc, imm;
      b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      a   = ($urandom_range(0, 3) == 0) ? b : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom);
      pc  = ($urandom & 32'h0000_01FC) | (($urandom_range(0, 15) == 0) ? 32'hFFFF_FE00 : 32'h0);
      imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom)) ) : $urandom;
      drive(($urandom_range(0, 3) != 0), pc, imm, a, b, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      rst     = ($urandom_range(0, 255) == 0);
      pred_pc = ($urandom_range(0, 1) == 0) ? pc : ($urandom & 32'h0000_01FC);
    end
    rst = 1'b0;
    idle();

`ifdef BRANCH_STATS_EN
    rst = 1'b1;
    idle();
    rst = 1'b0;
    drive(1'b1, 32'h500, 32'h4, 32'd5, 32'd5, 3'b000, 1'b1, 1'b0);
    drive(1'b1, 32'h504, 32'h4, 32'd5, 32'd6, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 32'h508, 32'h4, 32'd1, 32'd2, 3'b001, 1'b0, 1'b0);
    drive(1'b1, 32'h50C, 32'h4, 32'd1, 32'd2, 3'b101, 1'b1, 1'b0);
    drive(1'b1, 32'h510, 32'h4, 32'd1, 32'd2, 3'b011, 1'b1, 1'b0);
    drive(1'b1, 32'h514, 32'h4, 32'd1, 32'd1, 3'b000, 1'b0, 1'b1);
    idle();
    chk("stat_branches_lit", {32'd0, stat_branches}, 64'd4);
    chk("stat_mispredicts_lit", {32'd0, stat_mispredicts}, 64'd2);
`endif

    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction block for the integer pipeline. It evaluates RV32/RV64 conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) with a one-cycle registered result. It keeps a bimodal branch history table (BHT) of 2-bit saturating counters that fetch queries for a prediction. On every resolved branch it reports the taken decision, the branch target, a misprediction flag and the redirect PC, so fetch can be steered.

## Interface
- XLEN, 32: operand and PC width (32 or 64).
- BHT_ENTRIES, 64: number of 2-bit counters; power of two, minimum 2. IDX = log2(BHT_ENTRIES).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pred_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  combinational: MSB of BHT[pred_pc[IDX+1:2]].
- res_valid  in  1  a branch is presented for resolution this cycle.
- res_pc  in  XLEN  PC of the branch.
- res_imm  in  XLEN  sign-extended branch offset.
- rs1_d, rs2_d  in  XLEN  source operands.
- funct3  in  3  branch condition.
- res_pred_taken  in  1  prediction fetch used for this branch.
- flush  in  1  squash the branch presented this cycle.
- out_valid  out  1  registered: result fields are valid.
- branch  out  1  registered: condition true.
- target  out  XLEN  registered: res_pc + res_imm.
- redirect_pc  out  XLEN  registered: branch ? target : res_pc + 4.
- mispredict  out  1  registered: branch != res_pred_taken.
- illegal  out  1  registered: funct3 is 010 or 011.

## Operation
- Conditions: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE. All compares are full XLEN.
- Sums use XLEN-bit arithmetic and wrap modulo 2^XLEN. The target is not masked.
- Illegal funct3 forces branch=0 and mispredict=0, sets illegal=1, and leaves the BHT unchanged. redirect_pc = res_pc + 4.
- BHT counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is the counter MSB.
- BHT update fires when res_valid && !flush && legal funct3. Index is res_pc[IDX+1:2].
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
- Update is written at the clock edge. pred_taken read in the same cycle at the same index returns the old value.
- flush with res_valid: out_valid=0 next cycle and no BHT update.
- res_valid=0: out_valid=0 next cycle. Other outputs are don't-care but hold their previous values.

## Timing
- pred_taken: zero-cycle combinational read.
- Resolution latency is 1 cycle. Inputs are sampled at edge N and outputs are valid after edge N.
- Throughput is one branch per cycle. There is no backpressure.
- Back-to-back branches to the same index: the second branch resolves against the counter value updated by the first.
- Reset: out_valid, branch, mispredict and illegal are 0; target and redirect_pc are 0; every BHT counter is 01. pred_taken reads 0 in the cycle after reset.
- rst asserted mid-stream drops any in-flight result. out_valid=0 the cycle after reset, and no BHT update occurs on a reset edge.

## Configuration
- BRANCH_STATS_EN defined: adds outputs stat_branches and stat_mispredicts (each 32 bits, reset 0, wrapping).
  - stat_branches increments on each BHT-updating branch.
  - stat_mispredicts increments on each BHT-updating branch whose mispredict is 1.
- BRANCH_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then pred_pc=0x100 -> pred_taken=0. BEQ rs1=rs2=5, res_pc=0x100, imm=0x20, pred=0 -> next cycle: out_valid=1, branch=1, target=0x120, redirect_pc=0x120, mispredict=1.
- BLT rs1=0xFFFFFFFF, rs2=1 -> branch=1. BLTU with the same operands -> branch=0, redirect_pc=res_pc+4.
- Resolve the same PC as taken three times -> counter goes 01→10→11→11. pred_taken=1 after the first update; one not-taken then gives 10 and pred_taken is still 1.
- funct3=010, res_valid=1 -> illegal=1, branch=0, mispredict=0, BHT entry unchanged. With flush=1 on a valid BNE -> out_valid=0 and no counter change.
- res_pc=0xFFFFFFF0, imm=0x20 -> target=0x00000010 (wrap). Assert rst while a result is pending -> out_valid=0 and all counters return to 01.
- With BRANCH_STATS_EN: 4 legal branches, 2 of them mispredicted, plus 1 illegal and 1 flushed -> stat_branches=4, stat_mispredicts=2.
